frame_checker_impl: RTL and testbench

// Receive-side counterpart of the per-port test frame generator. Consumes the AXIS stream of test

---
 rtl/frame_checker_impl.sv | 244 ++++++++++++++++++++++++
 tb/tb_frame_checker_impl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_checker_impl.sv
// Receive-side test frame checker: validates header, checksum, length
// and payload pattern of returned test frames and keeps per-port stats.
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h00
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module frame_checker_impl #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [47:0]             check_dst_mac,
  input  logic [31:0]             check_src_ip,
  input  logic [31:0]             check_dst_ip,
  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready,
  output logic [CNT_WIDTH-1:0]    rx_frames,
  output logic [CNT_WIDTH-1:0]    rx_bytes,
  output logic [CNT_WIDTH-1:0]    good_frames,
  output logic [CNT_WIDTH-1:0]    err_frames
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int NL = DATA_WIDTH / 16;
  localparam int PW = $clog2(KW) + 1;

  typedef enum logic {
    WAIT_FIRST,
    IN_FRAME
  } state_t;

  state_t         state_q, state_d;
  logic           cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    ip_len_q, ip_len_d;
  logic           upd_q, upd_d;
  logic           upd_err_q, upd_err_d;
  logic [15:0]    upd_bytes_q, upd_bytes_d;

  logic [CNT_WIDTH-1:0] rx_frames_q, rx_frames_d;
  logic [CNT_WIDTH-1:0] rx_bytes_q, rx_bytes_d;
  logic [CNT_WIDTH-1:0] good_q, good_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic           unused_id;
  logic           acc;
  logic           first;
  logic [PW-1:0]  pop;
  logic [23:0]    csum_acc;
  logic [16:0]    csum_f1;
  logic [15:0]    csum_f2;
  logic           hdr_err;
  logic           pat_err;
  logic           pat_found;
  logic [15:0]    pat_ref;
  logic [15:0]    lane;
  int             lane_lo;
  logic           runt;
  logic           beat_err;
  logic [16:0]    len_sum;
  logic [15:0]    len_next;
  logic [15:0]    ip_len_cur;
  logic           len_err;
  logic           frame_err;
  logic           frame_cnt;

  assign unused_id    = ^axis_s_id;
  assign axis_s_ready = !rst;
  assign acc          = axis_s_valid && axis_s_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < KW; i++) begin
      pop = pop + {{(PW-1){1'b0}}, axis_s_keep[i]};
    end
  end

  // IP header checksum over bytes 14..33, big-endian words
  always_comb begin
    csum_acc = '0;
    for (int k = 0; k < 10; k++) begin
      csum_acc = csum_acc + {8'h00,
                             axis_s_data[8*(14+2*k) +: 8],
                             axis_s_data[8*(15+2*k) +: 8]};
    end
    csum_f1 = {1'b0, csum_acc[15:0]} + {9'h000, csum_acc[23:16]};
    csum_f2 = csum_f1[15:0] + {15'h0000, csum_f1[16]};
  end

  always_comb begin
    hdr_err = (axis_s_data[47:0]    != check_dst_mac)
           || (axis_s_data[103:96]  != 8'h08)
           || (axis_s_data[111:104] != 8'h00)
           || (axis_s_data[119:112] != 8'h45)
           || (axis_s_data[127:120] != `TEST_FRAME_TOS)
           || (axis_s_data[191:184] != `TEST_FRAME_PROTO)
           || (axis_s_data[239:208] != check_src_ip)
           || (axis_s_data[271:240] != check_dst_ip)
           || (csum_f2 != 16'hFFFF);
  end

  // Every fully kept 16-bit lane must match the first such lane
  always_comb begin
    pat_err   = 1'b0;
    pat_found = 1'b0;
    pat_ref   = '0;
    lane      = '0;
    lane_lo   = first ? 17 : 0;
    for (int i = 0; i < NL; i++) begin
      lane = axis_s_data[16*i +: 16];
      if (i >= lane_lo && axis_s_keep[2*i] && axis_s_keep[2*i+1]) begin
        if (!pat_found) begin
          pat_found = 1'b1;
          pat_ref   = lane;
        end else if (lane != pat_ref) begin
          pat_err = 1'b1;
        end
      end
    end
  end

  always_comb begin
    first = 1'b0;
    unique case (state_q)
      WAIT_FIRST: first = 1'b1;
      IN_FRAME:   first = 1'b0;
      default:    first = 1'b1;
    endcase
    runt       = first && axis_s_last && (pop < PW'(34));
    ip_len_cur = first ? {axis_s_data[135:128], axis_s_data[143:136]}
                       : ip_len_q;
    len_sum    = {1'b0, (first ? 16'h0000 : len_q)}
               + {{(17-PW){1'b0}}, pop};
    len_next   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    len_err    = axis_s_last
              && ({1'b0, len_next} != ({1'b0, ip_len_cur} + 17'd14));
    if (runt) begin
      beat_err = 1'b1;
    end else begin
      beat_err = (first && hdr_err) || pat_err
              || (axis_s_last && (|axis_s_user));
    end
    frame_err = (!first && err_q) || beat_err || len_err;
    frame_cnt = first ? enable : cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    len_d       = len_q;
    ip_len_d    = ip_len_q;
    upd_d       = 1'b0;
    upd_err_d   = upd_err_q;
    upd_bytes_d = upd_bytes_q;
    if (acc) begin
      if (axis_s_last) begin
        state_d     = WAIT_FIRST;
        err_d       = 1'b0;
        len_d       = '0;
        upd_d       = frame_cnt;
        upd_err_d   = frame_err;
        upd_bytes_d = len_next;
      end else begin
        state_d  = IN_FRAME;
        cnt_d    = frame_cnt;
        err_d    = frame_err;
        len_d    = len_next;
        ip_len_d = ip_len_cur;
      end
    end
  end

  // Clear takes priority: a pending frame update is dropped
  always_comb begin
    rx_frames_d = rx_frames_q;
    rx_bytes_d  = rx_bytes_q;
    good_d      = good_q;
    err_cnt_d   = err_cnt_q;
    if (clear) begin
      rx_frames_d = '0;
      rx_bytes_d  = '0;
      good_d      = '0;
      err_cnt_d   = '0;
    end else if (upd_q) begin
      rx_frames_d = rx_frames_q + CNT_WIDTH'(1);
      rx_bytes_d  = rx_bytes_q + CNT_WIDTH'(upd_bytes_q);
      if (upd_err_q) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end else begin
        good_d = good_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FIRST;
      cnt_q       <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      ip_len_q    <= '0;
      upd_q       <= 1'b0;
      upd_err_q   <= 1'b0;
      upd_bytes_q <= '0;
      rx_frames_q <= '0;
      rx_bytes_q  <= '0;
      good_q      <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      len_q       <= len_d;
      ip_len_q    <= ip_len_d;
      upd_q       <= upd_d;
      upd_err_q   <= upd_err_d;
      upd_bytes_q <= upd_bytes_d;
      rx_frames_q <= rx_frames_d;
      rx_bytes_q  <= rx_bytes_d;
      good_q      <= good_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_frames   = rx_frames_q;
  assign rx_bytes    = rx_bytes_q;
  assign good_frames = good_q;
  assign err_frames  = err_cnt_q;

endmodule

// File: tb/tb_frame_checker_impl.sv
// Directed bench for frame_checker_impl: builds test frames byte by
// byte, streams them as 64-byte beats and checks the statistics.
`timescale 1ns/1ps
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h00
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module tb_frame_checker_impl;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         clear;
  logic [47:0]  check_dst_mac = 48'h665544332211;
  logic [31:0]  check_src_ip  = 32'h0A01A8C0;
  logic [31:0]  check_dst_ip  = 32'h1402A8C0;
  logic [511:0] axis_s_data;
  logic [63:0]  axis_s_keep;
  logic         axis_s_last;
  logic [63:0]  axis_s_user;
  logic [2:0]   axis_s_id;
  logic         axis_s_valid;
  logic         axis_s_ready;
  logic [63:0]  rx_frames;
  logic [63:0]  rx_bytes;
  logic [63:0]  good_frames;
  logic [63:0]  err_frames;

  int errors = 0;
  int checks = 0;
  logic [7:0] fb [0:2047];

  frame_checker_impl dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .clear         (clear),
    .check_dst_mac (check_dst_mac),
    .check_src_ip  (check_src_ip),
    .check_dst_ip  (check_dst_ip),
    .axis_s_data   (axis_s_data),
    .axis_s_keep   (axis_s_keep),
    .axis_s_last   (axis_s_last),
    .axis_s_user   (axis_s_user),
    .axis_s_id     (axis_s_id),
    .axis_s_valid  (axis_s_valid),
    .axis_s_ready  (axis_s_ready),
    .rx_frames     (rx_frames),
    .rx_bytes      (rx_bytes),
    .good_frames   (good_frames),
    .err_frames    (err_frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [63:0] f,
                           input logic [63:0] b, input logic [63:0] g,
                           input logic [63:0] e);
    check({tag, ".rx_frames"}, rx_frames, f);
    check({tag, ".rx_bytes"}, rx_bytes, b);
    check({tag, ".good"}, good_frames, g);
    check({tag, ".err"}, err_frames, e);
  endtask

  task automatic fix_csum();
    logic [31:0] s;
    logic [15:0] c;
    fb[24] = 8'h00;
    fb[25] = 8'h00;
    s = 0;
    for (int k = 0; k < 10; k++) s += {16'h0, fb[14+2*k], fb[15+2*k]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    c = ~s[15:0];
    fb[24] = c[15:8];
    fb[25] = c[7:0];
  endtask

  task automatic build(input int len);
    logic [15:0] tl;
    tl = 16'(len - 14);
    for (int i = 0; i < 2048; i++) fb[i] = i[0] ? 8'h5A : 8'hA5;
    for (int j = 0; j < 6; j++) fb[j] = check_dst_mac[8*j +: 8];
    for (int j = 6; j < 12; j++) fb[j] = 8'h02;
    fb[12] = 8'h08; fb[13] = 8'h00;
    fb[14] = 8'h45; fb[15] = `TEST_FRAME_TOS;
    fb[16] = tl[15:8]; fb[17] = tl[7:0];
    fb[18] = 8'h12; fb[19] = 8'h34;
    fb[20] = 8'h40; fb[21] = 8'h00;
    fb[22] = 8'h40; fb[23] = `TEST_FRAME_PROTO;
    for (int j = 0; j < 4; j++) fb[26+j] = check_src_ip[8*j +: 8];
    for (int j = 0; j < 4; j++) fb[30+j] = check_dst_ip[8*j +: 8];
    fix_csum();
  endtask

  task automatic send(input int len, input bit user_last,
                      input int en_from, input bit clr_after);
    int nb;
    nb = (len + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
        axis_s_keep[i]      = (b*64 + i) < len;
        axis_s_data[8*i +: 8] = axis_s_keep[i] ? fb[b*64+i] : 8'h00;
      end
      axis_s_last  = (b == nb - 1);
      axis_s_user  = (axis_s_last && user_last) ? 64'h1 : 64'h0;
      axis_s_id    = 3'(b);
      axis_s_valid = 1'b1;
      enable       = (b >= en_from);
    end
    @(negedge clk);
    axis_s_valid = 1'b0;
    axis_s_last  = 1'b0;
    axis_s_user  = '0;
    clear        = clr_after;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    clear        = 1'b0;
    axis_s_data  = '0;
    axis_s_keep  = '0;
    axis_s_last  = 1'b0;
    axis_s_user  = '0;
    axis_s_id    = '0;
    axis_s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", 64'(axis_s_ready), 64'd0);
    check_cnt("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("run.ready", 64'(axis_s_ready), 64'd1);

    build(64);
    send(64, 0, 0, 0);
    check_cnt("good64", 1, 64, 1, 0);

    do_clear();
    check_cnt("cleared", 0, 0, 0, 0);
    build(1500);
    send(1500, 0, 0, 0);
    check_cnt("good1500", 1, 1500, 1, 0);

    do_clear();
    build(64);
    fb[24] = fb[24] ^ 8'hFF;
    send(64, 0, 0, 0);
    build(64);
    fb[23] = 8'h11;
    fix_csum();
    send(64, 0, 0, 0);
    build(64);
    fb[33] = fb[33] + 8'd1;
    fix_csum();
    send(64, 0, 0, 0);
    check_cnt("hdr_bad", 3, 192, 0, 3);

    do_clear();
    build(64);
    send(64, 1, 0, 0);
    build(128);
    fb[16] = 8'h00;
    fb[17] = 8'd100;
    fix_csum();
    send(128, 0, 0, 0);
    build(20);
    send(20, 0, 0, 0);
    check_cnt("len_bad", 3, 212, 0, 3);

    do_clear();
    build(128);
    send(128, 0, 1, 0);
    check_cnt("en_mid", 0, 0, 0, 0);
    build(64);
    send(64, 0, 0, 0);
    check_cnt("en_after", 1, 64, 1, 0);

    build(64);
    send(64, 0, 0, 1);
    check_cnt("clr_upd", 0, 0, 0, 0);

    build(128);
    @(negedge clk);
    for (int i = 0; i < 64; i++) axis_s_data[8*i +: 8] = fb[i];
    axis_s_keep  = '1;
    axis_s_last  = 1'b0;
    axis_s_valid = 1'b1;
    @(negedge clk);
    axis_s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.ready", 64'(axis_s_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    build(64);
    send(64, 0, 0, 0);
    check_cnt("after_rst", 1, 64, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
